// File: rtl/audio_mixer_seq.sv
// audio_mixer_seq: time-multiplexed signed audio mixer. One MAC stepped across
// channels, arithmetic shift by the gain fraction, saturation to OUT_WIDTH.
module audio_mixer_seq #(
  parameter int NUM_CHANNELS = 5,
  parameter int IN_WIDTH     = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int FRAC_BITS    = 4,
  parameter int OUT_WIDTH    = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             io_sampleValid,
  input  logic [NUM_CHANNELS*IN_WIDTH-1:0]   io_in,
  input  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] io_gain,
  input  logic [NUM_CHANNELS-1:0]          io_mute,
  output logic [OUT_WIDTH-1:0]             io_out,
  output logic                             io_outValid,
  output logic                             io_clip,
  output logic                             io_busy,
  output logic                             io_overrun
);
  localparam int CNT_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 0;
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
  localparam int ACC_W  = PROD_W + CNT_W;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_n;

  // Snapshot registers share the port packing, so a direct load lines up.
  logic [NUM_CHANNELS-1:0][IN_WIDTH-1:0]   samp_q;
  logic [NUM_CHANNELS-1:0][GAIN_WIDTH-1:0] gain_q;
  logic [NUM_CHANNELS-1:0]                 mute_q;

  logic        [IDX_W-1:0]      idx;
  logic signed [ACC_W-1:0]      acc;
  logic signed [IN_WIDTH-1:0]   samp_k;
  logic signed [GAIN_WIDTH:0]   gain_k;
  logic signed [PROD_W-1:0]     prod, term;
  logic signed [ACC_W-1:0]      shifted;
  logic        [OUT_WIDTH-1:0]  sat;
  logic                         clip_n, last;

  // Gain is zero-extended so the signed multiply treats it as non-negative.
  assign samp_k  = samp_q[idx];
  assign gain_k  = {1'b0, gain_q[idx]};
  assign prod    = samp_k * gain_k;
  assign term    = mute_q[idx] ? '0 : prod;
  assign last    = (idx == IDX_W'(NUM_CHANNELS - 1));
  assign shifted = acc >>> FRAC_BITS;
  assign io_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: one ACCUM cycle per channel, one DONE cycle to emit.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (io_sampleValid) state_n = ACCUM;
      ACCUM:   if (last)           state_n = DONE;
      DONE:                        state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  // Clamp the shifted sum to the output range and flag any change.
  always_comb begin
    sat    = shifted[OUT_WIDTH-1:0];
    clip_n = 1'b0;
    if (shifted > SAT_MAX) begin
      sat    = SAT_MAX[OUT_WIDTH-1:0];
      clip_n = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat    = SAT_MIN[OUT_WIDTH-1:0];
      clip_n = 1'b1;
    end
  end

  // Datapath: snapshot, multiply-accumulate, registered output and pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q      <= '0;
      gain_q      <= '0;
      mute_q      <= '0;
      acc         <= '0;
      idx         <= '0;
      io_out      <= '0;
      io_outValid <= 1'b0;
      io_clip     <= 1'b0;
      io_overrun  <= 1'b0;
    end else begin
      io_outValid <= 1'b0;
      io_overrun  <= io_sampleValid && (state != IDLE);
      case (state)
        IDLE: if (io_sampleValid) begin
          samp_q <= io_in;
          gain_q <= io_gain;
          mute_q <= io_mute;
          acc    <= '0;
          idx    <= '0;
        end
        ACCUM: begin
          acc <= acc + ACC_W'(term);
          idx <= last ? '0 : idx + 1'b1;
        end
        DONE: begin
          io_out      <= sat;
          io_clip     <= clip_n;
          io_outValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/audio_mixer_seq.md
# audio_mixer_seq

Parametrised, time-multiplexed audio mixer for the sound subsystem. Sums NUM_CHANNELS signed sound-chip outputs, each scaled by a runtime-programmable unsigned fixed-point gain and individually mutable. Produces one saturated signed sample per input sample strobe. Uses a single multiply-accumulate datapath stepped across channels, so channel count grows without growing multiplier count. Sits between the sound-chip outputs and the audio DAC/output formatter.

## Interface

Parameters:
- NUM_CHANNELS, 5, number of mixed channels (≥1)
- IN_WIDTH, 16, signed sample width per channel; narrower sources are sign-extended by the parent
- GAIN_WIDTH, 8, unsigned gain width per channel
- FRAC_BITS, 4, fractional bits of gain; unity gain = 2^FRAC_BITS
- OUT_WIDTH, 16, signed output width

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- io_sampleValid  in  1  one-cycle strobe: new input sample set present
- io_in  in  NUM_CHANNELS*IN_WIDTH  packed signed samples, channel k at bits [k*IN_WIDTH +: IN_WIDTH]
- io_gain  in  NUM_CHANNELS*GAIN_WIDTH  packed unsigned gains, same packing
- io_mute  in  NUM_CHANNELS  per-channel mute; 1 = channel contributes 0
- io_out  out  OUT_WIDTH  mixed signed sample, held between updates
- io_outValid  out  1  one-cycle pulse when io_out updates
- io_clip  out  1  valid with io_outValid; 1 = result was saturated
- io_busy  out  1  mix in progress; strobes are not accepted
- io_overrun  out  1  one-cycle pulse when a strobe is dropped

## Operation

- States: IDLE, ACCUM, DONE.
- IDLE: on io_sampleValid, snapshot io_in, io_gain and io_mute into internal registers, clear accumulator, set channel index to 0, go to ACCUM. Inputs may change freely after the snapshot edge.
- ACCUM: each cycle, acc += sample[k] * gain[k], or += 0 if mute[k]. Sample is signed and gain unsigned, so gain is zero-extended by one bit before a signed multiply. k increments each cycle; after k = NUM_CHANNELS-1, go to DONE.
- DONE: compute shifted = acc >>> FRAC_BITS (arithmetic shift, floor toward -inf).
  - Saturate shifted to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the result into io_out; pulse io_outValid; set io_clip = 1 iff saturation changed the value.
  - Return to IDLE.
- Accumulator width: IN_WIDTH + GAIN_WIDTH + 1 + ceil(log2(NUM_CHANNELS)). Overflow is impossible at any parameter setting.
- io_sampleValid while state ≠ IDLE: strobe dropped, io_overrun pulses the following cycle, the in-progress mix is unaffected.
- io_busy = (state ≠ IDLE).
- NUM_CHANNELS = 1 is legal: ACCUM lasts one cycle.
- Reset (any state, including mid-ACCUM):
  - State → IDLE; accumulator and index → 0.
  - io_out = 0, io_outValid = 0, io_clip = 0, io_overrun = 0.
  - The aborted mix never produces io_outValid.

## Timing

- Strobe sampled at edge 0.
- Channel k accumulated at edge k+1, for k = 0..NUM_CHANNELS-1.
- Output registered at edge NUM_CHANNELS+1: io_out, io_clip and io_outValid all change there. Latency is NUM_CHANNELS+1 cycles strobe-to-valid (6 at default).
- io_busy is high from after edge 0 until edge NUM_CHANNELS+1, and falls in the same cycle io_outValid rises.
- A strobe coincident with io_outValid high is accepted (state is IDLE). Minimum accepted strobe spacing is NUM_CHANNELS+2 cycles.
- io_out holds its value until the next io_outValid; io_clip holds likewise.
- No combinational path from any input to any output.

## Test plan

All scenarios use default parameters; gain 16 = unity.
- Unity single channel: in0 = 1000, others 0, all gains 16, no mute, strobe -> io_outValid exactly 6 cycles later, io_out = 1000, io_clip = 0, io_busy high for the 6 cycles between.
- Weighted sum: in = {1000, 2000, -500, 300, 0}, gains = {16, 3, 16, 104, 64} -> io_out = (16000 + 6000 - 8000 + 31200 + 0) >>> 4 = 2825, io_clip = 0.
- Saturation: all in = 20000, gains 16 -> io_out = 32767, io_clip = 1. All in = -20000 -> io_out = -32768, io_clip = 1.
- Rounding: in0 = -1, gain 8 -> io_out = -1. in0 = 1, gain 8 -> io_out = 0.
- Mute, snapshot and overrun: in0 = 1000 with mute0 = 1 -> io_out = 0. Changing io_in one cycle after the strobe does not alter the result. A second strobe 3 cycles after the first -> io_overrun pulse, exactly one io_outValid. A strobe in the io_outValid cycle -> accepted, next io_outValid 6 cycles later.
- Reset mid-ACCUM: assert reset 3 cycles after the strobe -> no io_outValid ever for that strobe, io_out = 0, io_busy = 0 after reset. A fresh strobe then mixes normally.
